// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage with a 2-entry (output + skid) result buffer.
// Valid/ready handshake: a transfer happens on any rising edge where valid && ready.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Packed result layout: {err, cout, zero, res}
  localparam int PW = WIDTH + 3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PW-1:0]    out_pkt;
  logic [PW-1:0]    skid_pkt;
  logic [PW-1:0]    fn_pkt;

  logic             sub_mode;
  logic [WIDTH-1:0] addend_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] f_res;
  logic             f_cout;
  logic             f_err;

  logic             accept;
  logic             drain;
  logic             load_out_fn;
  logic             load_out_skid;
  logic             load_skid;

  // SUB and SLT share the adder as a + ~b + 1
  assign sub_mode = (in_op == OP_SUB) || (in_op == OP_SLT);
  assign addend_b = sub_mode ? ~in_b : in_b;
  assign sum      = {1'b0, in_a} + {1'b0, addend_b} + {{WIDTH{1'b0}}, sub_mode};

  always_comb begin
    f_res  = '0;
    f_cout = 1'b0;
    f_err  = 1'b0;
    case (in_op)
      OP_AND: f_res = in_a & in_b;
      OP_OR:  f_res = in_a | in_b;
      OP_ADD, OP_SUB: begin
        f_res  = sum[WIDTH-1:0];
        f_cout = sum[WIDTH];
      end
      OP_XOR: f_res = in_a ^ in_b;
      OP_NOR: f_res = ~(in_a | in_b);
      OP_SLT: begin
        f_res  = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
        f_cout = sum[WIDTH];
      end
      default: f_err = 1'b1;
    endcase
  end

  assign fn_pkt = {f_err, f_cout, (f_res == '0), f_res};

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    load_out_fn   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt   = ONE;
          load_out_fn = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out_fn = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_nxt     = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready and out_valid are their own flops so neither leaks a combinational path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_pkt   <= '0;
      skid_pkt  <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      if (load_out_fn) begin
        out_pkt <= fn_pkt;
      end else if (load_out_skid) begin
        out_pkt <= skid_pkt;
      end
      if (load_skid) begin
        skid_pkt <= fn_pkt;
      end
    end
  end

  assign out_res  = out_pkt[WIDTH-1:0];
  assign out_zero = out_pkt[WIDTH];
  assign out_cout = out_pkt[WIDTH+1];
  assign out_err  = out_pkt[WIDTH+2];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and scoreboarded bench for alu_exec_stage.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic        out_cout;
  logic        out_err;

  int checks   = 0;
  int failures = 0;

  logic [34:0] exp_q[$];

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_cout  (out_cout),
    .out_err   (out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_res,
                           input logic ez, input logic ec, input logic ee);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"},   out_res,        e_res);
    check({tag, "_zero"},  32'(out_zero),  32'(ez));
    check({tag, "_cout"},  32'(out_cout),  32'(ec));
    check({tag, "_err"},   32'(out_err),   32'(ee));
  endtask

  // Reference model, written from the opcode table: {err, cout, zero, res}
  function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] s;
    logic [31:0] r;
    logic        c;
    logic        e;
    r = '0; c = 1'b0; e = 1'b0; s = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin s = {32'd0, a} + {32'd0, b}; r = s[31:0]; c = s[32]; end
      3'b011: r = a ^ b;
      3'b100: r = ~(a | b);
      3'b110: begin r = a - b; c = (a >= b); end
      3'b111: begin r = (a < b) ? 32'd1 : 32'd0; c = (a >= b); end
      default: e = 1'b1;
    endcase
    return {e, c, (r == 32'd0), r};
  endfunction

  // driver: issue one op with out_ready=1, check it one cycle later
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_res,
                        input logic ez, input logic ec, input logic ee);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_op = 3'($urandom_range(0, 7)); in_a = $urandom; in_b = $urandom;
    check_out(tag, e_res, ez, ec, ee);
  endtask

  initial begin
    logic [34:0] e;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0; in_valid = 1'b1; in_op = 3'b010; in_a = 32'd9; in_b = 32'd9; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_res",   out_res,        32'd0);
    check("rst_flags",     {29'd0, out_zero, out_cout, out_err}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // directed vectors, hand-computed
    run_op("and",      3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0, 0);
    run_op("or",       3'b001, 32'hA000_0005, 32'h0500_0030, 32'hA500_0035, 0, 0, 0);
    run_op("add",      3'b010, 32'd100,       32'd23,        32'd123,       0, 0, 0);
    run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 1, 0);
    run_op("xor",      3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 0, 0, 0);
    run_op("nor",      3'b100, 32'd0,         32'd0,         32'hFFFF_FFFF, 0, 0, 0);
    run_op("sub",      3'b110, 32'd10,        32'd4,         32'd6,         0, 1, 0);
    run_op("sub_eq",   3'b110, 32'd3,         32'd3,         32'd0,         1, 1, 0);
    run_op("sub_neg",  3'b110, 32'd0,         32'd1,         32'hFFFF_FFFF, 0, 0, 0);
    run_op("slt_lt",   3'b111, 32'd5,         32'd7,         32'd1,         0, 0, 0);
    run_op("slt_gt",   3'b111, 32'd7,         32'd5,         32'd0,         1, 1, 0);
    run_op("slt_big",  3'b111, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 1, 0);
    run_op("rsvd",     3'b101, 32'h1234_5678, 32'h1111_1111, 32'd0,         1, 0, 1);
    run_op("and_after",3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0);
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);

    // backpressure: A held, B in skid, C refused until drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b010; in_a = 32'd1; in_b = 32'd2;
    @(negedge clk);
    check_out("bp_a", 32'd3, 0, 0, 0);
    check("bp_ready1", 32'(in_ready), 32'd1);
    in_op = 3'b110; in_a = 32'd10; in_b = 32'd4;
    @(negedge clk);
    check_out("bp_a_hold", 32'd3, 0, 0, 0);
    check("bp_ready2", 32'(in_ready), 32'd0);
    in_op = 3'b011; in_a = 32'h0000_00FF; in_b = 32'h0000_000F;
    @(negedge clk);
    check_out("bp_a_hold2", 32'd3, 0, 0, 0);
    check("bp_ready3", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp_b", 32'd6, 0, 1, 0);
    check("bp_ready4", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_c", 32'h0000_00F0, 0, 0, 0);
    @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'd0);

    // throughput: 100 back-to-back random ops
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        check("tp_valid", 32'(out_valid), 32'd1);
        check("tp_ready", 32'(in_ready),  32'd1);
        if (exp_q.size() == 0) begin
          check("tp_queue", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("tp_res", out_res, e[31:0]);
          check("tp_flags", {29'd0, out_err, out_cout, out_zero}, {29'd0, e[34:32]});
        end
      end
      if (i < 100) begin
        rop = 3'($urandom_range(0, 7));
        ra  = (i % 7 == 0) ? rb : $urandom;
        rb  = $urandom;
        in_valid = 1'b1; in_op = rop; in_a = ra; in_b = rb;
        exp_q.push_back(model(rop, ra, rb));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("tp_drained", 32'(out_valid), 32'd0);
    check("tp_q_empty", 32'(exp_q.size()), 32'd0);

    // reset while FULL discards both entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b010; in_a = 32'd40; in_b = 32'd2;
    @(negedge clk);
    in_op = 3'b001; in_a = 32'h0000_0F00; in_b = 32'h0000_00F0;
    @(negedge clk);
    check("full_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0; in_op = 3'b010; in_a = 32'd7; in_b = 32'd7;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    check("frst_valid", 32'(out_valid), 32'd0);
    check("frst_ready", 32'(in_ready),  32'd1);
    check("frst_res",   out_res,        32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("frst_still_empty", 32'(out_valid), 32'd0);
    run_op("frst_add", 3'b010, 32'd2, 32'd3, 32'd5, 0, 0, 0);
    @(negedge clk);
    check("frst_no_stale", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("frst_no_stale2", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
